// File: rtl/rob_commit_queue_pkg.sv
// Shared RV32I pipeline types used by the reorder buffer and its neighbours.
package rv32i_types;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        regwrite;
    } pci_t;

    typedef struct packed {
        pci_t        pci;
        logic [31:0] data;
        logic        rdy;
        logic        mispredict;
    } sal2_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] front_tag;
    } flush_t;

    typedef struct packed {
        pci_t        pci;
        logic [31:0] data;
        logic        valid;
        logic        rdy;
        logic        mispredict;
        logic [31:0] target;
    } rob_entry_t;

    function automatic sal2_t make_rdest(input pci_t pci, input logic [31:0] data,
                                         input logic retired, input logic mispredict);
        sal2_t s;
        s.pci        = pci;
        s.data       = data;
        s.rdy        = retired;
        s.mispredict = mispredict;
        return s;
    endfunction

endpackage

// File: rtl/rob_commit_queue_if.sv
// Dispatch, writeback and retire signals between the core and the reorder buffer.
interface rob_commit_queue_if #(
    parameter int size  = 8,
    parameter int width = 32
);
    import rv32i_types::*;

    logic                    enq_valid;
    pci_t                    enq_pci;
    logic                    enq_ready;
    logic [$clog2(size)-1:0] enq_tag;
    logic                    wb_valid      [2];
    logic [$clog2(size)-1:0] wb_tag        [2];
    logic [width-1:0]        wb_data       [2];
    logic                    wb_mispredict [2];
    logic [31:0]             wb_target     [2];
    logic                    commit;
    sal2_t                   rdest         [size];
    int                      num_deq;
    flush_t                  flush;
    logic                    pc_load;
    logic [31:0]             pc_mux_out;

    modport master (
        output enq_valid, enq_pci, wb_valid, wb_tag, wb_data, wb_mispredict, wb_target,
        input  enq_ready, enq_tag, commit, rdest, num_deq, flush, pc_load, pc_mux_out
    );

    modport slave (
        input  enq_valid, enq_pci, wb_valid, wb_tag, wb_data, wb_mispredict, wb_target,
        output enq_ready, enq_tag, commit, rdest, num_deq, flush, pc_load, pc_mux_out
    );

endinterface

// File: rtl/rob_commit_queue_retire_select.sv
// Counts the contiguous valid+ready run starting at head, cut inclusively at the first mispredict.
module rob_retire_select #(
    parameter int size = 8
) (
    input  logic [size-1:0]         valid,
    input  logic [size-1:0]         rdy,
    input  logic [size-1:0]         mispredict,
    input  logic [$clog2(size)-1:0] head,
    output logic [$clog2(size):0]   n,
    output logic                    cut,
    output logic [$clog2(size)-1:0] cut_slot
);
    localparam int TW = $clog2(size);

    // Walk forward from head; the run closes at a non-ready slot or right after a mispredict.
    always_comb begin
        logic          open_s;
        logic [TW-1:0] slot_s;
        n        = '0;
        cut      = 1'b0;
        cut_slot = '0;
        open_s   = 1'b1;
        slot_s   = head;
        for (int i = 0; i < size; i++) begin
            slot_s = head + i[TW-1:0];
            if (open_s && valid[slot_s] && rdy[slot_s]) begin
                n = n + (TW+1)'(1);
                if (mispredict[slot_s]) begin
                    cut      = 1'b1;
                    cut_slot = slot_s;
                    open_s   = 1'b0;
                end else begin
                    open_s   = 1'b1;
                end
            end else begin
                open_s = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rob_commit_queue.sv
// Circular reorder buffer: in-order allocation, two writeback ports, grouped in-order retire
// with a registered retire report and a one-cycle redirect on a mispredicted branch.
module rob_commit_queue #(
    parameter int size  = 8,
    parameter int width = 32
) (
    input logic               clk,
    input logic               rst,
    rob_commit_queue_if.slave bus
);
    import rv32i_types::*;

    localparam int          TW       = $clog2(size);
    localparam logic [TW:0] FULL_CNT = (TW+1)'(size);

    rob_entry_t      entries_r   [size];
    rob_entry_t      entries_n_s [size];
    logic [TW-1:0]   head_r;
    logic [TW-1:0]   tail_r;
    logic [TW:0]     count_r;
    logic [TW-1:0]   head_n_s;
    logic [TW-1:0]   tail_n_s;
    logic [TW:0]     count_n_s;
    logic [size-1:0] valid_s;
    logic [size-1:0] rdy_s;
    logic [size-1:0] mis_s;
    logic [size-1:0] retired_s;
    logic [TW:0]     n_s;
    logic            cut_s;
    logic [TW-1:0]   cut_slot_s;
    logic            enq_fire_s;

    logic            commit_r;
    int              num_deq_r;
    flush_t          flush_r;
    logic            pc_load_r;
    logic [31:0]     pc_mux_out_r;
    sal2_t           rdest_r [size];

    assign bus.enq_ready  = (count_r != FULL_CNT) && !pc_load_r;
    assign bus.enq_tag    = tail_r;
    assign bus.commit     = commit_r;
    assign bus.num_deq    = num_deq_r;
    assign bus.flush      = flush_r;
    assign bus.pc_load    = pc_load_r;
    assign bus.pc_mux_out = pc_mux_out_r;
    assign bus.rdest      = rdest_r;

    // An enqueue in the same cycle as a mispredict retire is discarded by the flush.
    assign enq_fire_s = bus.enq_valid && bus.enq_ready && !cut_s;

    // Flatten per-slot status bits for the retire selector.
    always_comb begin
        valid_s = '0;
        rdy_s   = '0;
        mis_s   = '0;
        for (int i = 0; i < size; i++) begin
            valid_s[i] = entries_r[i].valid;
            rdy_s[i]   = entries_r[i].rdy;
            mis_s[i]   = entries_r[i].mispredict;
        end
    end

    rob_retire_select #(.size(size)) u_retire_select (
        .valid      (valid_s),
        .rdy        (rdy_s),
        .mispredict (mis_s),
        .head       (head_r),
        .n          (n_s),
        .cut        (cut_s),
        .cut_slot   (cut_slot_s)
    );

    // Mark the slots that leave the buffer this cycle.
    always_comb begin
        retired_s = '0;
        for (int i = 0; i < size; i++) begin
            retired_s[head_r + i[TW-1:0]] = ((TW+1)'(i) < n_s);
        end
    end

    // Next slot contents: writebacks (port 0 applied last so it wins), retire/flush clears, enqueue.
    always_comb begin
        logic [width-1:0] wdata_s;
        logic [TW-1:0]    tag_s;
        logic             hit_s;
        rob_entry_t       new_s;
        entries_n_s = entries_r;
        wdata_s     = '0;
        tag_s       = '0;
        hit_s       = 1'b0;
        for (int p = 1; p >= 0; p--) begin
            tag_s   = bus.wb_tag[p];
            wdata_s = bus.wb_data[p];
            hit_s   = bus.wb_valid[p] && entries_r[tag_s].valid;
            entries_n_s[tag_s].data       = hit_s ? XLEN'(wdata_s)       : entries_n_s[tag_s].data;
            entries_n_s[tag_s].rdy        = hit_s ? 1'b1                 : entries_n_s[tag_s].rdy;
            entries_n_s[tag_s].mispredict = hit_s ? bus.wb_mispredict[p] : entries_n_s[tag_s].mispredict;
            entries_n_s[tag_s].target     = hit_s ? bus.wb_target[p]     : entries_n_s[tag_s].target;
        end
        for (int i = 0; i < size; i++) begin
            entries_n_s[i].valid = entries_n_s[i].valid && !(retired_s[i] || cut_s);
            entries_n_s[i].rdy   = entries_n_s[i].rdy   && !(retired_s[i] || cut_s);
        end
        new_s            = '0;
        new_s.pci        = bus.enq_pci;
        new_s.valid      = 1'b1;
        entries_n_s[tail_r] = enq_fire_s ? new_s : entries_n_s[tail_r];
    end

    // Pointer and occupancy update; a flush collapses the buffer onto the new head.
    always_comb begin
        head_n_s  = head_r + n_s[TW-1:0];
        tail_n_s  = cut_s ? head_n_s : (tail_r + TW'(enq_fire_s));
        count_n_s = cut_s ? '0 : (count_r - n_s + (TW+1)'(enq_fire_s));
    end

    // Buffer state registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
            for (int i = 0; i < size; i++) begin
                entries_r[i] <= '0;
            end
        end else begin
            head_r  <= head_n_s;
            tail_r  <= tail_n_s;
            count_r <= count_n_s;
            for (int i = 0; i < size; i++) begin
                entries_r[i] <= entries_n_s[i];
            end
        end
    end

    // Registered retire report; rdest/num_deq/front_tag hold until the next non-empty retire.
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_r     <= 1'b0;
            num_deq_r    <= '0;
            flush_r      <= '0;
            pc_load_r    <= 1'b0;
            pc_mux_out_r <= '0;
            for (int i = 0; i < size; i++) begin
                rdest_r[i] <= '0;
            end
        end else begin
            commit_r      <= (n_s != '0);
            flush_r.valid <= cut_s;
            pc_load_r     <= cut_s;
            if (cut_s) begin
                pc_mux_out_r <= entries_r[cut_slot_s].target;
            end
            if (n_s != '0) begin
                num_deq_r         <= int'(n_s);
                flush_r.front_tag <= 8'(head_r);
                for (int i = 0; i < size; i++) begin
                    rdest_r[i] <= make_rdest(entries_r[i].pci, entries_r[i].data,
                                             retired_s[i], entries_r[i].mispredict);
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit_queue.sv
// Directed bench for rob_commit_queue: reset, single retire, full buffer, wrap, mispredict, port priority.
module tb_rob_commit_queue;
    import rv32i_types::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    rob_commit_queue_if #(.size(8), .width(32)) bus ();

    rob_commit_queue #(.size(8), .width(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        for (int p = 0; p < 2; p++) begin
            bus.wb_valid[p]      = 1'b0;
            bus.wb_tag[p]        = 3'd0;
            bus.wb_data[p]       = 32'd0;
            bus.wb_mispredict[p] = 1'b0;
            bus.wb_target[p]     = 32'd0;
        end
    endtask

    task automatic set_wb(input int p, input logic [2:0] tag, input logic [31:0] data,
                          input logic mis, input logic [31:0] tgt);
        bus.wb_valid[p]      = 1'b1;
        bus.wb_tag[p]        = tag;
        bus.wb_data[p]       = data;
        bus.wb_mispredict[p] = mis;
        bus.wb_target[p]     = tgt;
    endtask

    task automatic set_enq(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                           input logic [4:0] rd);
        bus.enq_valid        = v;
        bus.enq_pci.pc       = pc;
        bus.enq_pci.instr    = instr;
        bus.enq_pci.rd       = rd;
        bus.enq_pci.regwrite = 1'b1;
    endtask

    task automatic enq_n(input int k);
        for (int i = 0; i < k; i++) begin
            set_enq(1'b1, 32'h1000 + 32'(4 * i), 32'h00000013, 5'd0);
            tick();
        end
        bus.enq_valid = 1'b0;
    endtask

    task automatic do_reset();
        set_enq(1'b0, 32'd0, 32'd0, 5'd0);
        clr_wb();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.commit !== 1'b0) begin tests_failed++; $display("FAIL reset_commit got %0h exp 0", bus.commit); end
        tests_run++; if (bus.num_deq !== 0) begin tests_failed++; $display("FAIL reset_num_deq got %0d exp 0", bus.num_deq); end
        tests_run++; if (bus.flush !== 9'd0) begin tests_failed++; $display("FAIL reset_flush got %0h exp 0", bus.flush); end
        tests_run++; if (bus.pc_load !== 1'b0) begin tests_failed++; $display("FAIL reset_pc_load got %0h exp 0", bus.pc_load); end
        tests_run++; if (bus.pc_mux_out !== 32'd0) begin tests_failed++; $display("FAIL reset_pc_mux_out got %0h exp 0", bus.pc_mux_out); end
        tests_run++; if (bus.enq_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_enq_ready got %0h exp 1", bus.enq_ready); end
        tests_run++; if (bus.enq_tag !== 3'd0) begin tests_failed++; $display("FAIL reset_enq_tag got %0d exp 0", bus.enq_tag); end
        tests_run++; if (bus.rdest[7] !== '0) begin tests_failed++; $display("FAIL reset_rdest7 got %0h exp 0", bus.rdest[7]); end
    endtask

    task automatic test_single();
        do_reset();
        set_enq(1'b1, 32'h0, 32'h00500093, 5'd1);
        tick();
        bus.enq_valid = 1'b0;
        tests_run++; if (bus.enq_tag !== 3'd1) begin tests_failed++; $display("FAIL single_tail got %0d exp 1", bus.enq_tag); end
        set_wb(0, 3'd0, 32'd5, 1'b0, 32'd0);
        tick();
        clr_wb();
        tests_run++; if (bus.commit !== 1'b0) begin tests_failed++; $display("FAIL single_wb_latency got %0h exp 0", bus.commit); end
        tick();
        tests_run++; if (bus.commit !== 1'b1) begin tests_failed++; $display("FAIL single_commit got %0h exp 1", bus.commit); end
        tests_run++; if (bus.num_deq !== 1) begin tests_failed++; $display("FAIL single_num_deq got %0d exp 1", bus.num_deq); end
        tests_run++; if (bus.flush.front_tag !== 8'd0) begin tests_failed++; $display("FAIL single_front_tag got %0d exp 0", bus.flush.front_tag); end
        tests_run++; if (bus.rdest[0].rdy !== 1'b1) begin tests_failed++; $display("FAIL single_rdy0 got %0h exp 1", bus.rdest[0].rdy); end
        tests_run++; if (bus.rdest[0].data !== 32'd5) begin tests_failed++; $display("FAIL single_data0 got %0h exp 5", bus.rdest[0].data); end
        tests_run++; if (bus.rdest[0].pci.rd !== 5'd1) begin tests_failed++; $display("FAIL single_rd0 got %0d exp 1", bus.rdest[0].pci.rd); end
        tests_run++; if (bus.rdest[1].rdy !== 1'b0) begin tests_failed++; $display("FAIL single_rdy1 got %0h exp 0", bus.rdest[1].rdy); end
        tick();
        tests_run++; if (bus.commit !== 1'b0) begin tests_failed++; $display("FAIL single_commit_drop got %0h exp 0", bus.commit); end
        tests_run++; if (bus.num_deq !== 1) begin tests_failed++; $display("FAIL single_hold_num_deq got %0d exp 1", bus.num_deq); end
    endtask

    task automatic test_fill();
        do_reset();
        enq_n(8);
        tests_run++; if (bus.enq_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_enq_ready got %0h exp 0", bus.enq_ready); end
        tests_run++; if (bus.enq_tag !== 3'd0) begin tests_failed++; $display("FAIL fill_tail got %0d exp 0", bus.enq_tag); end
        set_enq(1'b1, 32'h9999, 32'h00000013, 5'd0);
        tick();
        bus.enq_valid = 1'b0;
        tests_run++; if (bus.enq_tag !== 3'd0) begin tests_failed++; $display("FAIL fill_overflow_tail got %0d exp 0", bus.enq_tag); end
        for (int t = 3; t >= 0; t--) begin
            set_wb(0, 3'(t), 32'd100 + 32'(t), 1'b0, 32'd0);
            tick();
            tests_run++; if (bus.commit !== 1'b0) begin tests_failed++; $display("FAIL fill_early_commit_t%0d got %0h exp 0", t, bus.commit); end
        end
        clr_wb();
        tick();
        tests_run++; if (bus.commit !== 1'b1) begin tests_failed++; $display("FAIL fill_commit got %0h exp 1", bus.commit); end
        tests_run++; if (bus.num_deq !== 4) begin tests_failed++; $display("FAIL fill_num_deq got %0d exp 4", bus.num_deq); end
        tests_run++; if (bus.flush.front_tag !== 8'd0) begin tests_failed++; $display("FAIL fill_front_tag got %0d exp 0", bus.flush.front_tag); end
        tests_run++; if (bus.rdest[3].data !== 32'd103) begin tests_failed++; $display("FAIL fill_data3 got %0d exp 103", bus.rdest[3].data); end
        tests_run++; if (bus.rdest[4].rdy !== 1'b0) begin tests_failed++; $display("FAIL fill_rdy4 got %0h exp 0", bus.rdest[4].rdy); end
        tests_run++; if (bus.enq_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_enq_ready_after got %0h exp 1", bus.enq_ready); end
    endtask

    task automatic test_wrap();
        do_reset();
        enq_n(6);
        set_wb(0, 3'd0, 32'h10, 1'b0, 32'd0); set_wb(1, 3'd1, 32'h11, 1'b0, 32'd0); tick();
        set_wb(0, 3'd2, 32'h12, 1'b0, 32'd0); set_wb(1, 3'd3, 32'h13, 1'b0, 32'd0); tick();
        set_wb(0, 3'd4, 32'h14, 1'b0, 32'd0); set_wb(1, 3'd5, 32'h15, 1'b0, 32'd0); tick();
        clr_wb();
        tick(); tick(); tick();
        tests_run++; if (bus.enq_tag !== 3'd6) begin tests_failed++; $display("FAIL wrap_tail6 got %0d exp 6", bus.enq_tag); end
        tests_run++; if (bus.num_deq !== 2 || bus.flush.front_tag !== 8'd4) begin tests_failed++; $display("FAIL wrap_hold got num_deq %0d front %0d exp 2 4", bus.num_deq, bus.flush.front_tag); end
        enq_n(4);
        tests_run++; if (bus.enq_tag !== 3'd2) begin tests_failed++; $display("FAIL wrap_tail2 got %0d exp 2", bus.enq_tag); end
        set_wb(0, 3'd7, 32'h17, 1'b0, 32'd0); set_wb(1, 3'd0, 32'h20, 1'b0, 32'd0); tick();
        set_wb(0, 3'd1, 32'h21, 1'b0, 32'd0); set_wb(1, 3'd6, 32'h16, 1'b0, 32'd0); tick();
        clr_wb();
        tests_run++; if (bus.commit !== 1'b0) begin tests_failed++; $display("FAIL wrap_early_commit got %0h exp 0", bus.commit); end
        tick();
        tests_run++; if (bus.num_deq !== 4) begin tests_failed++; $display("FAIL wrap_num_deq got %0d exp 4", bus.num_deq); end
        tests_run++; if (bus.flush.front_tag !== 8'd6) begin tests_failed++; $display("FAIL wrap_front_tag got %0d exp 6", bus.flush.front_tag); end
        tests_run++; if ({bus.rdest[6].rdy, bus.rdest[7].rdy, bus.rdest[0].rdy, bus.rdest[1].rdy} !== 4'b1111) begin tests_failed++; $display("FAIL wrap_rdy_6701 got %0b exp 1111", {bus.rdest[6].rdy, bus.rdest[7].rdy, bus.rdest[0].rdy, bus.rdest[1].rdy}); end
        tests_run++; if ({bus.rdest[2].rdy, bus.rdest[5].rdy} !== 2'b00) begin tests_failed++; $display("FAIL wrap_rdy_25 got %0b exp 00", {bus.rdest[2].rdy, bus.rdest[5].rdy}); end
        tests_run++; if (bus.rdest[0].data !== 32'h20) begin tests_failed++; $display("FAIL wrap_data0 got %0h exp 20", bus.rdest[0].data); end
        enq_n(1);
        set_wb(0, 3'd2, 32'h22, 1'b0, 32'd0); tick();
        clr_wb();
        tick();
        tests_run++; if (bus.commit !== 1'b1 || bus.flush.front_tag !== 8'd2) begin tests_failed++; $display("FAIL wrap_head2 got commit %0h front %0d exp 1 2", bus.commit, bus.flush.front_tag); end
    endtask

    task automatic test_mispredict();
        do_reset();
        enq_n(5);
        set_wb(0, 3'd3, 32'h3, 1'b0, 32'd0); set_wb(1, 3'd4, 32'h4, 1'b0, 32'd0); tick();
        set_wb(0, 3'd2, 32'h2, 1'b1, 32'h80); set_wb(1, 3'd1, 32'h1, 1'b0, 32'd0); tick();
        clr_wb();
        set_wb(0, 3'd0, 32'h0, 1'b0, 32'd0); tick();
        clr_wb();
        set_enq(1'b1, 32'h200, 32'h00000013, 5'd2);
        tick();
        tests_run++; if (bus.num_deq !== 3) begin tests_failed++; $display("FAIL mis_num_deq got %0d exp 3", bus.num_deq); end
        tests_run++; if (bus.pc_load !== 1'b1 || bus.flush.valid !== 1'b1) begin tests_failed++; $display("FAIL mis_redirect got pc_load %0h flush %0h exp 1 1", bus.pc_load, bus.flush.valid); end
        tests_run++; if (bus.pc_mux_out !== 32'h80) begin tests_failed++; $display("FAIL mis_target got %0h exp 80", bus.pc_mux_out); end
        tests_run++; if (bus.rdest[2].mispredict !== 1'b1 || bus.rdest[3].rdy !== 1'b0) begin tests_failed++; $display("FAIL mis_rdest got mis2 %0h rdy3 %0h exp 1 0", bus.rdest[2].mispredict, bus.rdest[3].rdy); end
        tests_run++; if (bus.enq_ready !== 1'b0 || bus.enq_tag !== 3'd3) begin tests_failed++; $display("FAIL mis_flush_tail got ready %0h tag %0d exp 0 3", bus.enq_ready, bus.enq_tag); end
        tick();
        tests_run++; if (bus.pc_load !== 1'b0 || bus.flush.valid !== 1'b0 || bus.commit !== 1'b0) begin tests_failed++; $display("FAIL mis_one_cycle got pc_load %0h flush %0h commit %0h exp 0 0 0", bus.pc_load, bus.flush.valid, bus.commit); end
        tests_run++; if (bus.enq_ready !== 1'b1 || bus.enq_tag !== 3'd3) begin tests_failed++; $display("FAIL mis_blocked_enq got ready %0h tag %0d exp 1 3", bus.enq_ready, bus.enq_tag); end
        tick();
        bus.enq_valid = 1'b0;
        tests_run++; if (bus.enq_tag !== 3'd4) begin tests_failed++; $display("FAIL mis_enq_landed got %0d exp 4", bus.enq_tag); end
        set_wb(0, 3'd3, 32'h33, 1'b0, 32'd0); set_wb(1, 3'd4, 32'h44, 1'b0, 32'd0); tick();
        clr_wb();
        tick();
        tests_run++; if (bus.num_deq !== 1 || bus.flush.front_tag !== 8'd3) begin tests_failed++; $display("FAIL mis_after got num_deq %0d front %0d exp 1 3", bus.num_deq, bus.flush.front_tag); end
        tests_run++; if (bus.rdest[3].data !== 32'h33 || bus.rdest[3].pci.pc !== 32'h200) begin tests_failed++; $display("FAIL mis_after_slot3 got data %0h pc %0h exp 33 200", bus.rdest[3].data, bus.rdest[3].pci.pc); end
    endtask

    task automatic test_same_tag();
        do_reset();
        enq_n(2);
        set_wb(0, 3'd1, 32'hA, 1'b0, 32'd0); set_wb(1, 3'd1, 32'hB, 1'b0, 32'd0); tick();
        clr_wb();
        set_wb(0, 3'd0, 32'h5, 1'b0, 32'd0); tick();
        clr_wb();
        tick();
        tests_run++; if (bus.num_deq !== 2) begin tests_failed++; $display("FAIL same_tag_num_deq got %0d exp 2", bus.num_deq); end
        tests_run++; if (bus.rdest[1].data !== 32'hA) begin tests_failed++; $display("FAIL same_tag_data got %0h exp a", bus.rdest[1].data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enq_n(3);
        set_wb(0, 3'd2, 32'h2, 1'b0, 32'd0); set_wb(1, 3'd1, 32'h1, 1'b0, 32'd0); tick();
        clr_wb();
        set_wb(0, 3'd0, 32'h7, 1'b0, 32'd0); tick();
        clr_wb();
        set_enq(1'b1, 32'h300, 32'h00000013, 5'd3);
        rst = 1'b0;
        tick();
        tests_run++; if (bus.commit !== 1'b0 || bus.num_deq !== 0) begin tests_failed++; $display("FAIL rstmid_commit got commit %0h num_deq %0d exp 0 0", bus.commit, bus.num_deq); end
        tests_run++; if (bus.flush !== 9'd0 || bus.pc_load !== 1'b0) begin tests_failed++; $display("FAIL rstmid_flush got flush %0h pc_load %0h exp 0 0", bus.flush, bus.pc_load); end
        tests_run++; if (bus.enq_tag !== 3'd0) begin tests_failed++; $display("FAIL rstmid_enq_tag got %0d exp 0", bus.enq_tag); end
        tests_run++; if (bus.rdest[0] !== '0) begin tests_failed++; $display("FAIL rstmid_rdest0 got %0h exp 0", bus.rdest[0]); end
        bus.enq_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        tests_run++; if (bus.commit !== 1'b0) begin tests_failed++; $display("FAIL rstmid_stale_retire got %0h exp 0", bus.commit); end
    endtask

    initial begin
        set_enq(1'b0, 32'd0, 32'd0, 5'd0);
        clr_wb();
        test_reset();
        test_single();
        test_fill();
        test_wrap();
        test_mispredict();
        test_same_tag();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rob_commit_queue.md
ROB_COMMIT_QUEUE -- requirements
Module: rob_commit_queue

Interface
REQ-001 SHALL have parameter size, default 8, meaning entry count (power of two).
REQ-002 SHALL have parameter width, default 32, meaning data width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1, meaning reset; synchronous, active-low.
REQ-005 SHALL have port enq_valid, input, 1, meaning dispatch offers one instruction.
REQ-006 SHALL have port enq_pci, input, pci_t, meaning the decoded instruction info.
REQ-007 SHALL have port enq_ready, output, 1, meaning a slot is free.
REQ-008 SHALL have port enq_tag, output, $clog2(size), meaning the slot to be allocated (current tail).
REQ-009 SHALL have ports wb_valid[2], wb_tag[2], wb_data[2] and wb_mispredict[2], all input, widths 1, $clog2(size), width and 1, meaning two writeback ports.
REQ-010 SHALL have port wb_target[2], input, 32, meaning the resolved redirect PC.
REQ-011 SHALL have port commit, output, 1, meaning at least one entry retired.
REQ-012 SHALL have port rdest[size], output, sal2_t, meaning per-slot retire info.
REQ-013 SHALL have port num_deq, output, int, meaning the count retired.
REQ-014 SHALL have port flush, output, flush_t, meaning front_tag (old head) and valid.
REQ-015 SHALL have ports pc_load, output, 1, and pc_mux_out, output, 32, meaning the fetch redirect.

Function
REQ-016 SHALL keep circular storage with head, tail and count (0..size) registers; enq_ready = (count != size) && !pc_load.
REQ-017 SHALL, on enq_valid && enq_ready, write enq_pci at tail with rdy=0 and valid=1, then advance tail by 1 modulo size.
REQ-018 SHALL, on wb_valid[p], set data, rdy and mispredict of slot wb_tag[p] when that slot is valid; writeback to an invalid slot is ignored.
REQ-019 SHALL give port 0 priority when both ports write the same tag in one cycle.
REQ-020 SHALL compute the retire group combinationally each cycle: contiguous valid && rdy entries starting at head, at most size, ending inclusively at the first mispredicted entry.
REQ-021 SHALL register the retire group outputs, one-cycle latency:
- commit = (n > 0) and num_deq = n.
- flush.front_tag = head before retire.
- rdest[i] = slot contents, with rdest[i].rdy = 1 only for the retired slots.
REQ-022 SHALL, at that same edge, advance head by n modulo size, clear valid of the retired slots, and reduce count by n, plus 1 if an enqueue also occurred.
REQ-023 SHALL make a writeback that arrives in the same cycle as a retire decision visible only to the next cycle's decision.
REQ-024 SHALL, if the group ends in a mispredict:
- invalidate all remaining entries and set tail = new head and count = 0.
- assert flush.valid and pc_load for exactly one cycle, with pc_mux_out = that entry's wb_target.
- drop any enqueue in that cycle.
REQ-025 SHALL hold rdest, num_deq and flush.front_tag stable while commit = 0; pc_load = 0 otherwise.
REQ-026 SHALL wrap all pointer arithmetic modulo size; full and empty SHALL be distinguished solely by count.

Reset
REQ-027 SHALL, when rst = 0 at posedge clk, clear head, tail, count and all valid/rdy bits, and set commit, num_deq, flush, pc_load and pc_mux_out to 0 and rdest to all zeros.
REQ-028 SHALL let reset override any concurrent enqueue, writeback or retire, including mid-flush.

Structure
REQ-029 SHALL take sal2_t, pci_t and flush_t from rv32i_types; a rob_entry_t (pci, data, valid, rdy, mispredict, target) SHALL be added to that package.
REQ-030 SHALL use one sub-module, rob_retire_select, a combinational contiguous-ready counter with mispredict cut.

Verification
REQ-031 SHALL cover: after reset, enqueue addi x1, x0, 5 at tag 0, then wb tag0 data 5 -> next cycle commit = 1, num_deq = 1, front_tag = 0, rdest[0].rdy = 1.
REQ-032 SHALL cover: fill 8 entries -> enq_ready = 0; wb tags 3..0 in reverse over 4 cycles -> single retire with num_deq = 4, front_tag = 0.
REQ-033 SHALL cover: head = 6 with 4 ready entries -> num_deq = 4, rdy set on slots 6, 7, 0 and 1, and head = 2.
REQ-034 SHALL cover: tag 2 is a branch with wb_mispredict and wb_target 0x80, tags 3 and 4 ready -> num_deq = 3 (tags 0..2), pc_load = 1, pc_mux_out = 0x80, count = 0, and the next-cycle enqueue lands at tag 3.
REQ-035 SHALL cover: both ports write tag 1 with data 0xA and 0xB -> the retired data is 0xA.
REQ-036 SHALL cover: rst = 0 asserted during a retire with 3 valid entries -> all outputs are 0 next cycle and enq_tag = 0.
